cle_pixel_sequencer: RTL and testbench

- Front-end sequencer for the component labeling engine.
- Walks the 128x8 packed binary image ROM (32x32 pixels, 1 bit/pixel) in raster order.
- Absorbs the ROM read latency with a prefetch and delivers one pixel per cycle over a valid/ready stream, tagged with row/column, to the labeling datapath.
- It is the only master of the ROM address bus.

---
 rtl/cle_pixel_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cle_pixel_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cle_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// cle_pixel_sequencer
// Front-end sequencer for the component labeling engine. Walks the 128x8
// packed binary image ROM (32x32 pixels, 1 bit/pixel) in raster order, hides
// the one-cycle ROM read latency with a prefetch and streams one pixel per
// cycle, tagged with row/column, over a valid/ready handshake.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   start      one-cycle scan request, ignored while a scan is in flight
//   rom_a      ROM byte address (this block is the only address master)
//   rom_q      ROM data for the address sampled at the previous edge
//   pix_valid  pixel beat valid
//   pix_ready  downstream accepts the beat
//   pix_val    pixel value (1 = object, 0 = background)
//   pix_row    pixel row 0..31
//   pix_col    pixel column 0..31
//   pix_last   marks the beat for row 31, col 31
//   busy       scan in progress
//   done       one-cycle pulse after the last beat is transferred
// -----------------------------------------------------------------------------
module cle_pixel_sequencer #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [6:0] rom_a,
    input  logic [7:0] rom_q,
    output logic       pix_valid,
    input  logic       pix_ready,
    output logic       pix_val,
    output logic [4:0] pix_row,
    output logic [4:0] pix_col,
    output logic       pix_last,
    output logic       busy,
    output logic       done
);

    localparam int unsigned BYTE_W    = 7;
    localparam int unsigned BIT_W     = 3;
    localparam logic [BYTE_W-1:0] LAST_BYTE = 7'd127;

    typedef enum logic [2:0] {
        IDLE,
        PRIME0,
        PRIME1,
        STREAM,
        DONE
    } state_t;

    state_t              state;
    logic [BYTE_W-1:0]   byte_idx;
    logic [BIT_W-1:0]    bit_idx;
    logic [7:0]          cur_byte;

    logic [BYTE_W-1:0]   byte_nxt;
    logic [BIT_W-1:0]    bit_nxt;
    logic [BYTE_W-1:0]   rom_a_adv;
    logic                xfer;

    // Select the pixel at bit position i of a byte, honouring pixel bit order.
    function automatic logic pick(input logic [7:0] b, input logic [BIT_W-1:0] i);
        return MSB_FIRST ? b[3'd7 - i] : b[i];
    endfunction

    // Index increments and the prefetch address for the byte after next.
    always_comb begin
        byte_nxt  = byte_idx + 7'd1;
        bit_nxt   = bit_idx + 3'd1;
        rom_a_adv = (byte_idx >= 7'd126) ? LAST_BYTE : byte_idx + 7'd2;
        xfer      = pix_valid && pix_ready;
    end

    // Scan FSM; every output is loaded with the value for the coming cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            byte_idx  <= '0;
            bit_idx   <= '0;
            cur_byte  <= '0;
            rom_a     <= '0;
            pix_valid <= 1'b0;
            pix_val   <= 1'b0;
            pix_row   <= '0;
            pix_col   <= '0;
            pix_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    rom_a <= '0;
                    if (start) begin
                        state <= PRIME0;
                        busy  <= 1'b1;
                    end
                end
                // ROM samples address 0 at the end of this cycle.
                PRIME0: begin
                    state <= PRIME1;
                    rom_a <= 7'd1;
                end
                // Byte 0 arrives; address 1 is launched so it is ready 8 beats on.
                PRIME1: begin
                    state     <= STREAM;
                    cur_byte  <= rom_q;
                    byte_idx  <= '0;
                    bit_idx   <= '0;
                    pix_valid <= 1'b1;
                    pix_val   <= pick(rom_q, 3'd0);
                    pix_row   <= '0;
                    pix_col   <= '0;
                    pix_last  <= 1'b0;
                end
                STREAM: begin
                    if (xfer) begin
                        if (pix_last) begin
                            state     <= DONE;
                            byte_idx  <= '0;
                            bit_idx   <= '0;
                            rom_a     <= '0;
                            pix_valid <= 1'b0;
                            pix_val   <= 1'b0;
                            pix_row   <= '0;
                            pix_col   <= '0;
                            pix_last  <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else if (bit_idx == 3'd7) begin
                            // rom_q has held byte_idx+1 since well before this edge.
                            cur_byte <= rom_q;
                            byte_idx <= byte_nxt;
                            bit_idx  <= '0;
                            pix_val  <= pick(rom_q, 3'd0);
                            pix_row  <= byte_nxt[6:2];
                            pix_col  <= {byte_nxt[1:0], 3'd0};
                            pix_last <= 1'b0;
                            rom_a    <= rom_a_adv;
                        end else begin
                            bit_idx  <= bit_nxt;
                            pix_val  <= pick(cur_byte, bit_nxt);
                            pix_col  <= {byte_idx[1:0], bit_nxt};
                            pix_last <= (byte_idx == LAST_BYTE) && (bit_nxt == 3'd7);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cle_pixel_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cle_pixel_sequencer
// Directed bench for cle_pixel_sequencer: one MSB-first instance with a
// behavioural ROM and a second LSB-first instance for bit-order checks.
// -----------------------------------------------------------------------------
module tb_cle_pixel_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic [6:0] rom_a;
    logic [7:0] rom_q;
    logic       pix_valid;
    logic       pix_ready;
    logic       pix_val;
    logic [4:0] pix_row;
    logic [4:0] pix_col;
    logic       pix_last;
    logic       busy;
    logic       done;

    logic       l_start;
    logic [6:0] l_rom_a;
    logic [7:0] l_rom_q;
    logic       l_valid;
    logic       l_ready;
    logic       l_val;
    logic [4:0] l_row;
    logic [4:0] l_col;
    logic       l_last;
    logic       l_busy;
    logic       l_done;

    logic [7:0] rom  [128];
    logic [7:0] lrom [128];

    // Synchronous ROMs: data reflects the address sampled at the previous edge.
    always @(posedge clk) rom_q   <= rom[rom_a];
    always @(posedge clk) l_rom_q <= lrom[l_rom_a];

    cle_pixel_sequencer #(.MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rom_a(rom_a), .rom_q(rom_q),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_val(pix_val),
        .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    cle_pixel_sequencer #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .start(l_start),
        .rom_a(l_rom_a), .rom_q(l_rom_q),
        .pix_valid(l_valid), .pix_ready(l_ready), .pix_val(l_val),
        .pix_row(l_row), .pix_col(l_col), .pix_last(l_last),
        .busy(l_busy), .done(l_done)
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int beat;
    int val_err, ord_err, last_err, stab_err, gap_err, extra_done;
    logic [7:0]  first_vals;
    bit          prev_stall;
    logic [21:0] prev_snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        total = total + 1;
        assert (obs === expd) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    function automatic logic [21:0] snap();
        return {rom_a, pix_valid, pix_val, pix_row, pix_col, pix_last, busy, done};
    endfunction

    // Reference pixel n of the MSB-first image.
    function automatic logic exp_bit(input int n);
        logic [7:0] b;
        b = rom[n / 8];
        return b[3'(7 - (n % 8))];
    endfunction

    task automatic clear_errs();
        val_err = 0; ord_err = 0; last_err = 0; stab_err = 0;
        gap_err = 0; extra_done = 0; prev_stall = 1'b0; first_vals = '0;
        beat = 0;
    endtask

    // Pulse start from IDLE and check the 3-edge latency to the first beat.
    task automatic start_scan(input string tag);
        clear_errs();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_busy_e1"}, 32'(busy), 32'd1);
        check({tag, "_valid_e1"}, 32'(pix_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid_e2"}, 32'(pix_valid), 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid_e3"}, 32'(pix_valid), 32'd1);
        check({tag, "_first_rowcol"}, 32'({pix_row, pix_col}), 32'd0);
        check({tag, "_first_val"}, 32'(pix_val), 32'(rom[0][7]));
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready high, random start pokes.
    task automatic stream(input int mode, input int stop_at);
        int cyc;
        cyc = 0;
        while (beat < stop_at && cyc < 5000) begin
            if (prev_stall && (snap() !== prev_snap)) stab_err++;
            if (!pix_valid) gap_err++;
            if (done) extra_done++;
            if (pix_valid) begin
                if (pix_row !== 5'(beat / 32) || pix_col !== 5'(beat % 32)) ord_err++;
                if (pix_val !== exp_bit(beat)) val_err++;
                if (pix_last !== (beat == 1023)) last_err++;
                if (beat < 8) first_vals[3'(beat)] = pix_val;
            end
            pix_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mode == 2) start = 1'($urandom_range(0, 1));
            prev_stall = pix_valid && !pix_ready;
            prev_snap  = snap();
            if (pix_valid && pix_ready) beat++;
            cyc++;
            @(posedge clk); #1;
        end
        start     = 1'b0;
        pix_ready = 1'b1;
    endtask

    // Called in the DONE cycle; optionally pokes start there.
    task automatic finish_checks(input string tag, input bit poke_start);
        check({tag, "_beats"}, 32'(beat), 32'd1024);
        check({tag, "_order_err"}, 32'(ord_err), 32'd0);
        check({tag, "_val_err"}, 32'(val_err), 32'd0);
        check({tag, "_last_err"}, 32'(last_err), 32'd0);
        check({tag, "_stall_stable_err"}, 32'(stab_err), 32'd0);
        check({tag, "_valid_gap_err"}, 32'(gap_err), 32'd0);
        check({tag, "_done_pulse"}, 32'({done, busy, pix_valid}), 32'b100);
        start = poke_start;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_cleared"}, 32'({done, busy, pix_valid}), 32'b000);
    endtask

    initial begin
        int idle_err;
        reset = 1'b1; start = 1'b0; pix_ready = 1'b1;
        l_start = 1'b0; l_ready = 1'b1;
        for (int i = 0; i < 128; i++) begin
            rom[i]  = 8'($urandom);
            lrom[i] = 8'($urandom);
        end
        rom[0]  = 8'hA5;
        rom[3]  = 8'hFF;
        rom[4]  = 8'h00;
        lrom[0] = 8'h01;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_outputs", 32'(snap()), 32'd0);
        check("reset_lsb_outputs", 32'({l_rom_a, l_valid, l_val, l_row, l_col, l_last, l_busy, l_done}), 32'd0);
        @(posedge clk); #1;
        check("idle_hold", 32'(snap()), 32'd0);

        // Full-rate scan: byte0=A5 gives 1,0,1,0,0,1,0,1 on beats 0..7.
        start_scan("full");
        stream(0, 1024);
        check("full_first8", 32'(first_vals), 32'hA5);
        finish_checks("full", 1'b0);

        // Random backpressure.
        start_scan("rand");
        stream(1, 1024);
        finish_checks("rand", 1'b0);

        // Stall on beat (0,31) with byte3=FF, byte4=00.
        start_scan("stall");
        stream(0, 31);
        check("stall_rom_a_pre", 32'(rom_a), 32'd4);
        check("stall_beat_0_31", 32'({pix_row, pix_col, pix_val}), 32'({5'd0, 5'd31, 1'b1}));
        pix_ready = 1'b0;
        idle_err = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (rom_a !== 7'd4 || pix_valid !== 1'b1 || pix_row !== 5'd0 ||
                pix_col !== 5'd31 || pix_val !== 1'b1) idle_err++;
        end
        check("stall_hold_err", 32'(idle_err), 32'd0);
        pix_ready = 1'b1;
        @(posedge clk); #1;
        beat = 32;
        check("stall_beat_1_0", 32'({pix_valid, pix_row, pix_col, pix_val}), 32'({1'b1, 5'd1, 5'd0, 1'b0}));
        stream(0, 1024);
        finish_checks("stall", 1'b0);

        // start pokes during STREAM and in the DONE cycle are ignored.
        start_scan("poke");
        stream(2, 1024);
        check("poke_extra_done", 32'(extra_done), 32'd0);
        finish_checks("poke", 1'b1);
        idle_err = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (busy !== 1'b0 || pix_valid !== 1'b0 || done !== 1'b0) idle_err++;
        end
        check("poke_done_start_ignored", 32'(idle_err), 32'd0);

        // Synchronous reset after 300 transfers, then a fresh scan.
        start_scan("rst");
        stream(1, 300);
        check("rst_beats_before", 32'(beat), 32'd300);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_outputs_zero", 32'(snap()), 32'd0);
        @(posedge clk); #1;
        check("rst_idle_hold", 32'(snap()), 32'd0);
        start_scan("rst2");
        stream(0, 1024);
        finish_checks("rst2", 1'b0);

        // LSB-first instance: byte0=01 gives 1 then seven 0s.
        l_start = 1'b1;
        @(posedge clk); #1;
        l_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("lsb_valid_e3", 32'(l_valid), 32'd1);
        check("lsb_beat0", 32'(l_val), 32'd1);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("lsb_beat%0d", i), 32'({l_col, l_val}), 32'({5'(i), 1'b0}));
        end
        idle_err = 1;
        for (int i = 0; i < 1100 && idle_err != 0; i++) begin
            @(posedge clk); #1;
            if (l_done) idle_err = 0;
        end
        check("lsb_done_seen", 32'(idle_err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
